mfp_ahb_uart_tx: RTL and testbench
==================================

# mfp_ahb_uart_tx

AHB-Lite slave that transmits bytes from the MIPS core over a serial line, 8N1 format, LSB first. It is the transmit counterpart to the UART_RX serial-load path. It sits on the mfp_ahb_withloader bus as an extra peripheral slot. Writes are buffered in a small FIFO, and a baud-rate FSM drains the FIFO onto UART_TX.

## Interface
- CLKS_PER_BIT, default 434, HCLK cycles per bit (50 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, default 8, TX FIFO entries. Must be a power of two, 2..16.
- HCLK  in  1  bus clock; the block's only clock.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- HSEL  in  1  slave select from the bus decoder.
- HADDR  in  32  address; only HADDR[2] is decoded. 0 = TXDATA, 1 = STATUS.
- HTRANS  in  2  transfer type; HTRANS[1]=1 marks an active transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; every access is treated as word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready, qualifies the address phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied to 1 (zero wait states).
- HRESP  out  1  tied to 0 (OKAY).
- UART_TX  out  1  serial line, idle high.
- TX_IRQ  out  1  level output, high when the FIFO is empty and the FSM is idle.

## Operation
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, register the write flag and HADDR[2]. The data phase is the following cycle.
- Write to TXDATA: push HWDATA[7:0] at the end of the data phase.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky flag ovf is set.
- Write to STATUS: writing HWDATA[3]=1 clears ovf. All other bits are ignored.
- Read of STATUS returns:
  - [0] empty
  - [1] full
  - [2] busy (FSM not IDLE)
  - [3] ovf
  - [8 +: 5] count
  - all other bits 0
- Read of TXDATA returns 0. Reads have no side effects.
- HRDATA is combinational from the registered data-phase address and current state. It is 0 when there is no read data phase.
- FIFO: circular buffer with count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves count unchanged.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty. On that transition, pop the FIFO into shift register sh[7:0].
  - START → DATA after CLKS_PER_BIT cycles; UART_TX=0 during START.
  - DATA: drives sh[0] for CLKS_PER_BIT cycles, then shifts right and increments the bit index 0..7. After bit 7, go to STOP.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Bit timer: down-counter, 16 bits wide, loaded with CLKS_PER_BIT-1 on each state or bit entry. A bit ends when the counter reaches 0.
- UART_TX is driven from a register, so it is glitch-free.
- TX_IRQ = empty & (state==IDLE), registered.

## Timing
- Reset values:
  - UART_TX=1, TX_IRQ=1, HRDATA=0
  - FSM=IDLE, count=0, pointers=0, ovf=0, bit timer=0
  - HREADYOUT=1, HRESP=0 (constant)
- Write latency from an idle state:
  - Data phase ends at edge E1; count becomes 1.
  - At E2 the FSM pops and UART_TX falls.
  - First start bit is visible 2 cycles after the address phase.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames: the STOP→IDLE edge is followed by one IDLE cycle, then START. The idle gap is exactly 1 cycle when the FIFO is non-empty.
- TX_IRQ falls on the edge after the first push, or one cycle later. It rises on the edge after STOP completes with the FIFO empty.
- Status read in the same data phase as a push reflects the pre-push count.
- Reset asserted mid-frame: UART_TX returns to 1 asynchronously, the FIFO contents are discarded, and no partial frame resumes after reset.
- Back-to-back accesses, one per cycle, are sustained with no stalls.

## Test plan
- **Single byte.** CLKS_PER_BIT=4. Write 0xA5 to TXDATA.
  - UART_TX samples at bit centres: 0,1,0,1,0,0,1,0,1,1.
  - Frame is 40 cycles, first falling edge 2 cycles after the address phase.
  - TX_IRQ goes 1→0→1.
- **Burst.** Write 0x01, 0x02, 0x03 back-to-back.
  - Three frames, each separated by exactly 1 idle-high cycle.
  - STATUS.count reads 2 immediately after the third write (first byte already popped).
- **Overflow.** FIFO_DEPTH=8. Hold the FSM busy and write 10 bytes in consecutive cycles.
  - 9 bytes are transmitted (8 buffered + 1 popped), in order.
  - STATUS[3]=1.
  - Writing STATUS with 0x8 clears it to 0.
- **Full with simultaneous pop.** Push while full in the same cycle the FSM pops.
  - Byte accepted, count stays 8, ovf stays 0.
- **Reset mid-frame.** Assert HRESETn=0 during DATA bit 4.
  - UART_TX=1 immediately.
  - After release, STATUS reads 0x1 and no further frame appears.
- **Bus qualification.** HTRANS=IDLE or HSEL=0 with HWRITE=1 to TXDATA.
  - No push.
  - HRDATA=0.
  - HREADYOUT=1 throughout.

Source files
------------

// File: rtl/mfp_ahb_uart_tx.sv
// rtl/mfp_ahb_uart_tx.sv - AHB-Lite slave that buffers bytes in a FIFO and sends them as 8N1 serial frames
module mfp_ahb_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        UART_TX,
    output logic        TX_IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] T_LOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_d;
    logic [15:0] timer, timer_d;
    logic [2:0]  bit_idx, bit_d;
    logic [7:0]  sh, sh_d;
    logic        tx_d, irq_d;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        empty, full, push_req, push, pop, drop, clr_ovf, ovf;

    logic        dp_valid, dp_write, dp_addr, accept;
    logic [4:0]  count5;
    logic [31:0] status;
    logic        unused;

    assign unused    = ^{HSIZE, HADDR[31:3], HADDR[1:0], HWDATA[31:8], HTRANS[0]};
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign accept   = HSEL & HTRANS[1] & HREADY;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign push_req = dp_valid & dp_write & ~dp_addr;
    // A full FIFO still takes the byte when the FSM frees a slot on the same edge
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & ~push;
    assign clr_ovf  = dp_valid & dp_write & dp_addr & HWDATA[3];

    assign count5 = 5'(count);
    assign status = {19'd0, count5, 4'd0, ovf, (state != IDLE), full, empty};
    assign HRDATA = (dp_valid & ~dp_write & dp_addr) ? status : 32'd0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            UART_TX  <= 1'b1;
            TX_IRQ   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            bit_idx  <= bit_d;
            sh       <= sh_d;
            UART_TX  <= tx_d;
            TX_IRQ   <= irq_d;
            dp_valid <= accept;
            dp_write <= HWRITE;
            dp_addr  <= HADDR[2];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= HWDATA[7:0];
    end

    always_comb begin
        state_d = state;
        timer_d = timer;
        bit_d   = bit_idx;
        sh_d    = sh;
        pop     = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                state_d = START;
                timer_d = T_LOAD;
                sh_d    = mem[rd_ptr];
                pop     = 1'b1;
            end
            START: if (timer == '0) begin
                state_d = DATA;
                timer_d = T_LOAD;
                bit_d   = 3'd0;
            end else timer_d = timer - 16'd1;
            DATA: if (timer == '0) begin
                timer_d = T_LOAD;
                sh_d    = sh >> 1;
                if (bit_idx == 3'd7) state_d = STOP;
                else                 bit_d = bit_idx + 3'd1;
            end else timer_d = timer - 16'd1;
            STOP: if (timer == '0) state_d = IDLE;
                  else             timer_d = timer - 16'd1;
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so the register changes on the same edge as the FSM
    always_comb begin
        tx_d  = 1'b1;
        irq_d = empty & (state == IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// tb/tb_mfp_ahb_uart_tx.sv - directed bench with a frame scoreboard for mfp_ahb_uart_tx
module tb_mfp_ahb_uart_tx;
    localparam int CPB = 4;
    localparam int GAP = 10 * CPB + 1;

    logic        HCLK = 1'b0;
    logic        HRESETn, HSEL, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT, HRESP, UART_TX, TX_IRQ;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] sb[$];
    int falls[$];

    mfp_ahb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .UART_TX(UART_TX), .TX_IRQ(TX_IRQ)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic a2, input logic [31:0] wd);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = {29'd0, a2, 2'b00};
        HWDATA = wd;
        @(negedge HCLK);
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp);
        step(1'b1, 2'b10, 1'b0, 1'b1, 32'd0);
        chk(tag, HRDATA, exp);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic write_byte(input logic [7:0] b);
        step(1'b1, 2'b10, 1'b1, 1'b0, 32'd0);
        step(1'b0, 2'b00, 1'b0, 1'b0, {24'hFFFF00, b});
    endtask

    task automatic wait_falls(input int n, input string tag);
        int t = 0;
        while (falls.size() < n && t < 600) begin
            @(negedge HCLK);
            t++;
        end
        chk(tag, 32'(falls.size() >= n), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 1200) begin
            @(negedge HCLK);
            t++;
        end
        chk(tag, sb.size(), 0);
    endtask

    // Frame decoder: samples bit centres, aborts on reset, scores complete frames
    logic       prev_tx = 1'b1;
    logic [9:0] frame;
    logic       ab;
    logic [7:0] exp_b;
    always begin
        @(negedge HCLK);
        if (HRESETn && prev_tx && !UART_TX) begin
            falls.push_back(cyc);
            ab = 1'b0;
            for (int k = 0; k < 10 && !ab; k++) begin
                for (int w = 0; w < (k == 0 ? CPB / 2 : CPB) && !ab; w++) begin
                    @(negedge HCLK);
                    if (!HRESETn) ab = 1'b1;
                end
                frame[k] = UART_TX;
            end
            if (!ab) begin
                if (sb.size() == 0) chk("unexpected_frame", {22'd0, frame}, 32'hFFFF_FFFF);
                else begin
                    exp_b = sb.pop_front();
                    chk("frame", {22'd0, frame}, {22'd0, 1'b1, exp_b, 1'b0});
                end
            end
        end
        prev_tx = UART_TX;
    end

    initial begin
        int a_cyc, nf, p;
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = '0; HWDATA = '0; HSIZE = 3'd2; HREADY = 1'b1;
        @(negedge HCLK);
        chk("rst_uart_tx", UART_TX, 1);
        chk("rst_irq", TX_IRQ, 1);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        read_status("rst_status", 32'h1);

        // Unqualified transfers must not push
        step(1'b0, 2'b10, 1'b1, 1'b0, 32'd0);
        step(1'b1, 2'b00, 1'b1, 1'b0, 32'h55);
        chk("qual_hrdata0", HRDATA, 0);
        chk("qual_ready0", HREADYOUT, 1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h66);
        chk("qual_hrdata1", HRDATA, 0);
        chk("qual_ready1", HREADYOUT, 1);
        repeat (4) @(negedge HCLK);
        read_status("qual_status", 32'h1);
        chk("qual_no_frame", falls.size(), 0);

        // Single byte
        step(1'b1, 2'b10, 1'b1, 1'b0, 32'd0);
        a_cyc = cyc;
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'hA5);
        sb.push_back(8'hA5);
        wait_falls(1, "single_fall");
        chk("single_latency", falls[0], a_cyc + 2);
        chk("single_irq_low", TX_IRQ, 0);
        wait_drain("single_drain");
        repeat (6) @(negedge HCLK);
        chk("single_irq_high", TX_IRQ, 1);
        chk("single_idle_line", UART_TX, 1);

        // Burst of three with status read after the third write
        nf = falls.size();
        step(1'b1, 2'b10, 1'b1, 1'b0, 32'd0);
        step(1'b1, 2'b10, 1'b1, 1'b0, 32'h01);
        step(1'b1, 2'b10, 1'b1, 1'b0, 32'h02);
        step(1'b1, 2'b10, 1'b0, 1'b1, 32'h03);
        sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
        chk("burst_status", HRDATA, 32'h204);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'd0);
        wait_falls(nf + 3, "burst_falls");
        chk("burst_gap0", falls[nf + 1] - falls[nf], GAP);
        chk("burst_gap1", falls[nf + 2] - falls[nf + 1], GAP);
        wait_drain("burst_drain");
        repeat (6) @(negedge HCLK);

        // Overflow: ten writes, nine fit
        nf = falls.size();
        step(1'b1, 2'b10, 1'b1, 1'b0, 32'd0);
        for (int i = 1; i < 10; i++) step(1'b1, 2'b10, 1'b1, 1'b0, 32'h10 + i - 1);
        step(1'b1, 2'b10, 1'b0, 1'b1, 32'h19);
        for (int i = 0; i < 9; i++) sb.push_back(8'(8'h10 + i));
        chk("ovf_status", HRDATA, 32'h80E);
        step(1'b1, 2'b10, 1'b1, 1'b1, 32'd0);
        step(1'b1, 2'b10, 1'b0, 1'b1, 32'h8);
        chk("ovf_cleared", HRDATA, 32'h806);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'd0);

        // Refill to full, then push on the exact edge the FSM pops
        wait_falls(nf + 2, "full_pop_sync");
        p = falls[nf + 1];
        write_byte(8'h2A);
        sb.push_back(8'h2A);
        read_status("full_before", 32'h806);
        while (cyc < p + GAP - 2) @(negedge HCLK);
        step(1'b1, 2'b10, 1'b1, 1'b0, 32'd0);
        step(1'b1, 2'b10, 1'b0, 1'b1, 32'h2B);
        sb.push_back(8'h2B);
        chk("full_pop_status", HRDATA, 32'h806);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'd0);
        wait_drain("ovf_drain");
        repeat (6) @(negedge HCLK);
        chk("ovf_irq_high", TX_IRQ, 1);

        // Reset during data bit 4 of 0xC3 (that bit is 0)
        nf = falls.size();
        write_byte(8'hC3);
        wait_falls(nf + 1, "rst_frame_fall");
        p = falls[nf];
        while (cyc < p + 5 * CPB + 1) @(negedge HCLK);
        chk("rst_pre_bit4", UART_TX, 0);
        #2 HRESETn = 1'b0;
        #1 chk("rst_async_tx", UART_TX, 1);
        chk("rst_async_irq", TX_IRQ, 1);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        read_status("rst_after_status", 32'h1);
        repeat (60) @(negedge HCLK);
        chk("rst_no_resume", falls.size(), nf + 1);
        chk("rst_line_idle", UART_TX, 1);
        chk("sb_empty_end", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
